// File: rtl/bcd_converter_if.sv
//------------------------------------------------------------------------------
// Module      : bcd_converter_if
// Description : AHB-Lite slave bus bundle for the binary-to-BCD converter.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface bcd_converter_if;
  logic [31:0] HADDR;
  logic [31:0] HWDATA;
  logic        HWRITE;
  logic        HREADY;
  logic        HSEL;
  logic [2:0]  HSIZE;
  logic [1:0]  HTRANS;
  logic [31:0] HRDATA;
  logic        HREADYOUT;

  modport master (
    output HADDR, HWDATA, HWRITE, HREADY, HSEL, HSIZE, HTRANS,
    input  HRDATA, HREADYOUT
  );

  modport slave (
    input  HADDR, HWDATA, HWRITE, HREADY, HSEL, HSIZE, HTRANS,
    output HRDATA, HREADYOUT
  );
endinterface

`default_nettype wire

// File: rtl/bcd_converter.sv
//------------------------------------------------------------------------------
// Module      : bcd_converter
// Description : AHB-Lite slave converting a 14-bit binary operand into four
//               packed BCD digits with a one-bit-per-clock double-dabble engine.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bcd_converter (
  input  wire logic       HCLK,
  input  wire logic       HRESET,
  bcd_converter_if.slave  bus
);

  localparam logic [1:0]  ADDR_OPERAND = 2'd0;
  localparam logic [1:0]  ADDR_STATUS  = 2'd1;
  localparam logic [1:0]  ADDR_RESULT  = 2'd2;
  localparam logic [3:0]  LAST_ITER    = 4'd13;
  localparam logic [13:0] MAX_DECIMAL  = 14'd9999;
  localparam logic [15:0] SATURATED    = 16'h9999;

  logic        xfer;
  logic        wr_q, wr_d;
  logic        rd_q, rd_d;
  logic [1:0]  addr_q, addr_d;
  logic [13:0] operand_q, operand_d;
  logic [13:0] shift_q, shift_d;
  logic [15:0] bcd_q, bcd_d;
  logic [15:0] result_q, result_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        ovf_q, ovf_d;
  logic        load;
  logic [15:0] bcd_adj;
  logic [31:0] rdata;
  logic        unused_bits;

  // Add-3 correction applied to every digit before each shift.
  for (genvar i = 0; i < 4; i++) begin : g_adj
    assign bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3
                                                         : bcd_q[4*i +: 4];
  end

  assign load = wr_q && (addr_q == ADDR_OPERAND);

  always_comb begin
    xfer   = bus.HSEL && bus.HREADY && (bus.HTRANS != 2'b00);
    wr_d   = xfer && bus.HWRITE;
    rd_d   = xfer && !bus.HWRITE;
    addr_d = xfer ? bus.HADDR[3:2] : 2'b00;

    operand_d = operand_q;
    shift_d   = shift_q;
    bcd_d     = bcd_q;
    result_d  = result_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = done_q;
    ovf_d     = ovf_q;

    // A new operand always wins, even on the completion edge of a prior one.
    if (load) begin
      operand_d = bus.HWDATA[13:0];
      shift_d   = bus.HWDATA[13:0];
      bcd_d     = 16'h0000;
      cnt_d     = 4'd0;
      busy_d    = 1'b1;
      done_d    = 1'b0;
      ovf_d     = 1'b0;
    end else if (busy_q) begin
      bcd_d   = {bcd_adj[14:0], shift_q[13]};
      shift_d = {shift_q[12:0], 1'b0};
      cnt_d   = cnt_q + 4'd1;
      if (cnt_q == LAST_ITER) begin
        busy_d = 1'b0;
        done_d = 1'b1;
        if (operand_q > MAX_DECIMAL) begin
          result_d = SATURATED;
          ovf_d    = 1'b1;
        end else begin
          result_d = bcd_d;
        end
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      addr_q    <= 2'b00;
      operand_q <= 14'd0;
      shift_q   <= 14'd0;
      bcd_q     <= 16'h0000;
      result_q  <= 16'h0000;
      cnt_q     <= 4'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      addr_q    <= addr_d;
      operand_q <= operand_d;
      shift_q   <= shift_d;
      bcd_q     <= bcd_d;
      result_q  <= result_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
    end
  end

  always_comb begin
    rdata = 32'h0000_0000;
    if (rd_q) begin
      case (addr_q)
        ADDR_OPERAND: rdata = {18'h0, operand_q};
        ADDR_STATUS:  rdata = {29'h0, ovf_q, done_q, busy_q};
        ADDR_RESULT:  rdata = {16'h0, result_q};
        default:      rdata = 32'h0000_0000;
      endcase
    end
  end

  assign bus.HRDATA    = rdata;
  assign bus.HREADYOUT = 1'b1;

  assign unused_bits = &{1'b0, bus.HSIZE, bus.HADDR[31:4], bus.HADDR[1:0],
                         bus.HWDATA[31:14], bcd_adj[15]};

endmodule

`default_nettype wire

// File: tb/tb_bcd_converter.sv
// Scoreboard bench for bcd_converter: reads push expected data at issue,
// a negedge monitor pops and compares during each read data phase.
`default_nettype none

module tb_bcd_converter;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  logic HCLK   = 1'b0;
  logic HRESET = 1'b1;

  bcd_converter_if bus ();

  bcd_converter dut (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .bus    (bus)
  );

  always #5 HCLK = ~HCLK;

  int          n_checks = 0;
  int          n_pass   = 0;
  exp_t        exp_q[$];
  logic        rd_issued  = 1'b0;
  logic        dp_rd      = 1'b0;
  logic        started    = 1'b0;
  logic [31:0] wdata_pipe = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
  endtask

  always @(posedge HCLK) begin
    dp_rd   <= HRESET ? 1'b0 : rd_issued;
    started <= 1'b1;
  end

  always @(negedge HCLK) begin
    if (started) begin
      check("hreadyout", {31'h0, bus.HREADYOUT}, 32'h1);
      if (dp_rd) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_read: got 0x%08h, want no read at %0t", bus.HRDATA, $time);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check(e.name, bus.HRDATA, e.val);
        end
      end else begin
        check("idle_hrdata", bus.HRDATA, 32'h0);
      end
    end
  end

  task automatic bus_cyc(input logic sel, input logic [1:0] trans, input logic wr,
                         input logic [1:0] a, input logic [31:0] d);
    bus.HWDATA = wdata_pipe;
    wdata_pipe = d;
    bus.HSEL   = sel;
    bus.HTRANS = trans;
    bus.HWRITE = wr;
    bus.HADDR  = {28'h4000100, a, 2'b00};
    bus.HSIZE  = 3'b010;
    bus.HREADY = 1'b1;
    rd_issued  = sel && (trans != 2'b00) && !wr;
    @(posedge HCLK);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus_cyc(1'b1, 2'b10, 1'b1, a, d);
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
    exp_t e;
    e.name = name;
    e.val  = exp;
    exp_q.push_back(e);
    bus_cyc(1'b1, 2'b10, 1'b0, a, 32'h0);
  endtask

  task automatic idle();
    bus_cyc(1'b0, 2'b00, 1'b0, 2'd0, 32'h0);
  endtask

  // Write, poll STATUS every cycle across the whole busy window, then read back.
  task automatic convert(input logic [13:0] val, input logic [31:0] res,
                         input logic [31:0] st, input string name);
    wr(2'd0, {18'h0, val});
    for (int k = 0; k < 14; k++) rd(2'd1, 32'h1, {name, "_busy"});
    rd(2'd1, st, {name, "_status"});
    rd(2'd2, res, {name, "_result"});
    rd(2'd0, {18'h0, val}, {name, "_operand"});
  endtask

  initial begin
    bus.HWDATA = 32'h0;
    bus.HSEL   = 1'b0;
    bus.HTRANS = 2'b00;
    bus.HWRITE = 1'b0;
    bus.HADDR  = 32'h0;
    bus.HSIZE  = 3'b010;
    bus.HREADY = 1'b1;

    idle();
    idle();
    HRESET = 1'b0;

    rd(2'd0, 32'h0, "rst_operand");
    rd(2'd1, 32'h0, "rst_status");
    rd(2'd2, 32'h0, "rst_result");
    rd(2'd3, 32'h0, "rst_reserved");
    idle();

    convert(14'd1234,  32'h0000_1234, 32'h2, "c1234");
    convert(14'd0,     32'h0000_0000, 32'h2, "c0");
    convert(14'd9999,  32'h0000_9999, 32'h2, "c9999");
    convert(14'd10000, 32'h0000_9999, 32'h6, "c10000");
    convert(14'd16383, 32'h0000_9999, 32'h6, "c16383");
    convert(14'd9,     32'h0000_0009, 32'h2, "c9");
    convert(14'd10,    32'h0000_0010, 32'h2, "c10");

    // Ignored writes to STATUS, RESULT and reserved space.
    wr(2'd1, 32'hFFFF_FFFF);
    wr(2'd2, 32'h0000_5555);
    wr(2'd3, 32'h0000_0001);
    rd(2'd1, 32'h2, "ro_status");
    rd(2'd2, 32'h0000_0010, "ro_result");
    rd(2'd3, 32'h0, "ro_reserved");
    idle();

    // Abort: 4321 then 56 five cycles later; RESULT must go 0x0010 -> 0x0056.
    wr(2'd0, 32'd4321);
    for (int k = 0; k < 4; k++) rd(2'd1, 32'h1, "abort_busy_a");
    wr(2'd0, 32'd56);
    for (int k = 0; k < 14; k++) begin
      if (k % 2 == 0) rd(2'd1, 32'h1, "abort_busy_b");
      else            rd(2'd2, 32'h0000_0010, "abort_old_result");
    end
    rd(2'd1, 32'h2, "abort_status");
    rd(2'd2, 32'h0000_0056, "abort_result");
    idle();

    // Restart landing on the completion edge of 777.
    wr(2'd0, 32'd777);
    for (int k = 0; k < 13; k++) rd(2'd1, 32'h1, "coll_busy_a");
    wr(2'd0, 32'd42);
    rd(2'd1, 32'h1, "coll_status_restart");
    rd(2'd2, 32'h0000_0056, "coll_result_kept");
    for (int k = 0; k < 12; k++) rd(2'd1, 32'h1, "coll_busy_b");
    rd(2'd1, 32'h2, "coll_status_done");
    rd(2'd2, 32'h0000_0042, "coll_result");
    rd(2'd0, 32'd42, "coll_operand");
    idle();

    // Reset at iteration 7 of 5000.
    wr(2'd0, 32'd5000);
    for (int k = 0; k < 6; k++) rd(2'd1, 32'h1, "mrst_busy");
    idle();
    HRESET = 1'b1;
    idle();
    HRESET = 1'b0;
    rd(2'd1, 32'h0, "mrst_status");
    rd(2'd2, 32'h0, "mrst_result");
    rd(2'd0, 32'h0, "mrst_operand");
    idle();

    // IDLE transfer with HSEL high must not start a conversion.
    bus_cyc(1'b1, 2'b00, 1'b1, 2'd0, 32'd1234);
    rd(2'd1, 32'h0, "idle_xfer_status");
    rd(2'd0, 32'h0, "idle_xfer_operand");
    idle();
    idle();

    check("queue_drain", exp_q.size(), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
